ram_dp_be_init: RTL and testbench

//  Single-clock true dual-port RAM, DEPTH x WIDTH, two read/write ports (A, B) with per-byte write enables.

---
 rtl/ram_dp_pkg.sv | 34 +++
 rtl/ram_dp_init_seq.sv | 60 ++++++
 rtl/ram_dp_be_init.sv | 165 ++++++++++++++++
 tb/tb_ram_dp_be_init.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM with init sweep.
package ram_dp_pkg;

    // Widest word the byte-merge helper handles; wider RAMs need this raised.
    localparam int unsigned MAX_WIDTH = 1024;
    localparam int unsigned MAX_IDX_W = $clog2(MAX_WIDTH);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_t;

    // Number of byte-enable lanes in a word.
    function automatic int unsigned lane_count(input int unsigned width,
                                               input int unsigned byte_w);
        return width / byte_w;
    endfunction

    // Lane-wise merge: lanes with be set take new_w, the rest keep old_w.
    function automatic logic [MAX_WIDTH-1:0] byte_merge(input logic [MAX_WIDTH-1:0] old_w,
                                                        input logic [MAX_WIDTH-1:0] new_w,
                                                        input logic [MAX_WIDTH-1:0] be,
                                                        input int unsigned          byte_w);
        logic [MAX_WIDTH-1:0] r;
        r = old_w;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (be[MAX_IDX_W'(i / byte_w)]) begin
                r[MAX_IDX_W'(i)] = new_w[MAX_IDX_W'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_dp_init_seq.sv
// Post-reset initialisation sequencer: walks every address once, then parks in READY.
module ram_dp_init_seq
    import ram_dp_pkg::*;
#(
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_busy,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              sweep_we_c
);

    init_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    // State, sweep counter and busy flag; reset restarts the sweep at address 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: one sweep write per cycle, leave INIT after the last address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == INIT);
    end

    assign init_busy  = busy_q;
    assign sweep_addr = cnt_q;
    assign sweep_we_c = (state_q == INIT);

endmodule

// File: rtl/ram_dp_be_init.sv
// Single-clock true dual-port RAM with per-byte write enables, write-through on
// same/cross-port collisions (port A wins shared lanes) and a post-reset init sweep.
// Optional feature macro: RAM_DP_BE_INIT_OUTREG_EN adds an output register stage
// on q_a/q_b (read latency 2 instead of 1).
module ram_dp_be_init
    import ram_dp_pkg::*;
#(
    parameter int unsigned       DEPTH      = 2048,
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       BYTE_WIDTH = 8,
    parameter logic [WIDTH-1:0]  INIT_VALUE = '0,
    localparam int unsigned      DEPTH_BITS = $clog2(DEPTH),
    localparam int unsigned      LANES      = WIDTH / BYTE_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  init_busy,
    input  logic [DEPTH_BITS-1:0] address_a,
    input  logic                  wren_a,
    input  logic [LANES-1:0]      byteena_a,
    input  logic [WIDTH-1:0]      data_a,
    output logic [WIDTH-1:0]      q_a,
    input  logic [DEPTH_BITS-1:0] address_b,
    input  logic                  wren_b,
    input  logic [LANES-1:0]      byteena_b,
    input  logic [WIDTH-1:0]      data_b,
    output logic [WIDTH-1:0]      q_b
);

    logic [WIDTH-1:0]      mem [DEPTH];

    logic [DEPTH_BITS-1:0] sweep_addr;
    logic                  sweep_we_c;

    logic [WIDTH-1:0]      old_a_c, old_b_c;
    logic [WIDTH-1:0]      word_a_c, word_b_c;
    logic                  wa_en_c, wb_en_c, same_addr_c, both_c;
    logic                  w0_en_c, w1_en_c;
    logic [DEPTH_BITS-1:0] w0_addr_c, w1_addr_c;
    logic [WIDTH-1:0]      w0_data_c, w1_data_c;

    logic [WIDTH-1:0]      q_a_q, q_a_d;
    logic [WIDTH-1:0]      q_b_q, q_b_d;

    function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] old_w,
                                                 input logic [WIDTH-1:0] new_w,
                                                 input logic [LANES-1:0] be);
        return WIDTH'(byte_merge(MAX_WIDTH'(old_w), MAX_WIDTH'(new_w),
                                 MAX_WIDTH'(be), BYTE_WIDTH));
    endfunction

    ram_dp_init_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (DEPTH_BITS)
    ) u_init_seq (
        .clock      (clock),
        .reset      (reset),
        .init_busy  (init_busy),
        .sweep_addr (sweep_addr),
        .sweep_we_c (sweep_we_c)
    );

    // Collision merge and write-port mux: slot 0 carries the sweep or port A
    // (with B folded in on a shared address), slot 1 carries port B otherwise.
    always_comb begin
        old_a_c     = mem[address_a];
        old_b_c     = mem[address_b];
        same_addr_c = (address_a == address_b);
        wa_en_c     = !sweep_we_c && !reset && wren_a;
        wb_en_c     = !sweep_we_c && !reset && wren_b;
        both_c      = wa_en_c && wb_en_c && same_addr_c;

        word_b_c    = merge_w(old_b_c, data_b, byteena_b);
        word_a_c    = merge_w(old_a_c, data_a, byteena_a);
        if (both_c) begin
            word_a_c = merge_w(word_b_c, data_a, byteena_a);
        end

        w0_en_c   = 1'b0;
        w0_addr_c = address_a;
        w0_data_c = word_a_c;
        if (sweep_we_c) begin
            w0_en_c   = !reset;
            w0_addr_c = sweep_addr;
            w0_data_c = INIT_VALUE;
        end else begin
            w0_en_c   = wa_en_c;
        end

        w1_en_c   = wb_en_c && !both_c;
        w1_addr_c = address_b;
        w1_data_c = word_b_c;
    end

    // Read-next values: zero while sweeping, otherwise the post-write word at each address.
    always_comb begin
        q_a_d = old_a_c;
        q_b_d = old_b_c;
        if (sweep_we_c) begin
            q_a_d = '0;
            q_b_d = '0;
        end else begin
            if (wa_en_c) begin
                q_a_d = word_a_c;
            end else if (wb_en_c && same_addr_c) begin
                q_a_d = word_b_c;
            end
            if (wa_en_c && same_addr_c) begin
                q_b_d = word_a_c;
            end else if (wb_en_c) begin
                q_b_d = word_b_c;
            end
        end
    end

    // Storage array; contents are not reset, the sweep initialises them.
    always_ff @(posedge clock) begin
        if (w0_en_c) begin
            mem[w0_addr_c] <= w0_data_c;
        end
        if (w1_en_c) begin
            mem[w1_addr_c] <= w1_data_c;
        end
    end

    // First read-data register stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            q_a_q <= q_a_d;
            q_b_q <= q_b_d;
        end
    end

`ifdef RAM_DP_BE_INIT_OUTREG_EN
    logic [WIDTH-1:0] q_a_out_q, q_a_out_d;
    logic [WIDTH-1:0] q_b_out_q, q_b_out_d;

    // Extra output stage: same data, one cycle later.
    always_comb begin
        q_a_out_d = q_a_q;
        q_b_out_d = q_b_q;
    end

    // Output register stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_a_out_q <= '0;
            q_b_out_q <= '0;
        end else begin
            q_a_out_q <= q_a_out_d;
            q_b_out_q <= q_b_out_d;
        end
    end

    assign q_a = q_a_out_q;
    assign q_b = q_b_out_q;
`else
    assign q_a = q_a_q;
    assign q_b = q_b_q;
`endif

endmodule

// File: tb/tb_ram_dp_be_init.sv
// Directed self-checking bench for ram_dp_be_init (DEPTH=16, WIDTH=32).
module tb_ram_dp_be_init;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned LN    = 4;
    localparam logic [31:0] IV    = 32'hA5A5A5A5;
`ifdef RAM_DP_BE_INIT_OUTREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic             clock;
    logic             reset;
    logic             init_busy;
    logic [AW-1:0]    address_a, address_b;
    logic             wren_a, wren_b;
    logic [LN-1:0]    byteena_a, byteena_b;
    logic [WIDTH-1:0] data_a, data_b;
    logic [WIDTH-1:0] q_a, q_b;

    int vec_cnt;
    int err_cnt;

    ram_dp_be_init #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .BYTE_WIDTH (8),
        .INIT_VALUE (IV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .init_busy (init_busy),
        .address_a (address_a),
        .wren_a    (wren_a),
        .byteena_a (byteena_a),
        .data_a    (data_a),
        .q_a       (q_a),
        .address_b (address_b),
        .wren_b    (wren_b),
        .byteena_b (byteena_b),
        .data_b    (data_b),
        .q_b       (q_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wren_a = 1'b0; wren_b = 1'b0;
        byteena_a = '0; byteena_b = '0;
        data_a = '0; data_b = '0;
    endtask

    // Counts busy cycles after reset release; expects exactly DEPTH with q held at 0.
    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        vec_cnt++;
        if (init_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s busy_at_release: got %b want 1", tag, init_busy);
        end
        while (init_busy === 1'b1 && n < 64) begin
            vec_cnt++;
            if (q_a !== '0 || q_b !== '0) begin
                err_cnt++;
                $display("FAIL %s q_during_init: q_a=%h q_b=%h want 0", tag, q_a, q_b);
            end
            step();
            n++;
        end
        vec_cnt++;
        if (n != DEPTH) begin
            err_cnt++;
            $display("FAIL %s sweep_cycles: got %0d want %0d", tag, n, DEPTH);
        end
    endtask

    task automatic test_reset();
        idle();
        address_a = '0; address_b = '0;
        reset = 1'b1;
        #2;
        vec_cnt++;
        if (init_busy !== 1'b1 || q_a !== '0 || q_b !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: busy=%b q_a=%h q_b=%h want 1/0/0", init_busy, q_a, q_b);
        end
        step(); step();
        reset = 1'b0;
        wait_sweep("reset");
    endtask

    task automatic test_init_contents();
        for (int i = 0; i < int'(DEPTH); i++) begin
            address_a = AW'(i);
            address_b = AW'(DEPTH - 1 - i);
            repeat (LAT) step();
            vec_cnt++;
            if (q_a !== IV || q_b !== IV) begin
                err_cnt++;
                $display("FAIL init_word[%0d]: q_a=%h q_b=%h want %h", i, q_a, q_b, IV);
            end
        end
    endtask

    task automatic test_byte_write();
        address_a = 4'd3; address_b = 4'd3;
        wren_a = 1'b1; byteena_a = 4'b0101; data_a = 32'h11223344;
        step();
        idle();
        repeat (LAT - 1) step();
        vec_cnt++;
        if (q_a !== 32'hA522A544) begin
            err_cnt++;
            $display("FAIL be_write_through_a: got %h want A522A544", q_a);
        end
        vec_cnt++;
        if (q_b !== 32'hA522A544) begin
            err_cnt++;
            $display("FAIL be_write_cross_b: got %h want A522A544", q_b);
        end
        address_a = 4'd4; address_b = 4'd4;
        repeat (LAT) step();
        address_a = 4'd3;
        repeat (LAT) step();
        vec_cnt++;
        if (q_a !== 32'hA522A544) begin
            err_cnt++;
            $display("FAIL be_readback: got %h want A522A544", q_a);
        end
    endtask

    task automatic test_dual_write_collision();
        address_a = 4'd5; address_b = 4'd5;
        wren_a = 1'b1; byteena_a = 4'b1100; data_a = 32'hFFFFFFFF;
        wren_b = 1'b1; byteena_b = 4'b0110; data_b = 32'h00000000;
        step();
        idle();
        repeat (LAT - 1) step();
        vec_cnt++;
        if (q_a !== 32'hFFFF00A5 || q_b !== 32'hFFFF00A5) begin
            err_cnt++;
            $display("FAIL collision_q: q_a=%h q_b=%h want FFFF00A5", q_a, q_b);
        end
        address_a = 4'd0; address_b = 4'd0;
        repeat (LAT) step();
        address_a = 4'd5; address_b = 4'd5;
        repeat (LAT) step();
        vec_cnt++;
        if (q_a !== 32'hFFFF00A5 || q_b !== 32'hFFFF00A5) begin
            err_cnt++;
            $display("FAIL collision_mem: q_a=%h q_b=%h want FFFF00A5", q_a, q_b);
        end
    endtask

    task automatic test_cross_port_write_through();
        address_a = 4'd7; address_b = 4'd7;
        repeat (LAT) step();
        vec_cnt++;
        if (q_a !== IV) begin
            err_cnt++;
            $display("FAIL cross_pre: got %h want %h", q_a, IV);
        end
        wren_b = 1'b1; byteena_b = 4'hF; data_b = 32'hDEADBEEF;
        step();
        idle();
        vec_cnt++;
`ifdef RAM_DP_BE_INIT_OUTREG_EN
        if (q_a !== IV) begin
            err_cnt++;
            $display("FAIL cross_lat2_early: got %h want %h", q_a, IV);
        end
        step();
`else
        if (q_a !== 32'hDEADBEEF) begin
            err_cnt++;
            $display("FAIL cross_lat1: got %h want DEADBEEF", q_a);
        end
`endif
        vec_cnt++;
        if (q_a !== 32'hDEADBEEF || q_b !== 32'hDEADBEEF) begin
            err_cnt++;
            $display("FAIL cross_write_through: q_a=%h q_b=%h want DEADBEEF", q_a, q_b);
        end
    endtask

    task automatic test_independent();
        address_a = 4'd10; wren_a = 1'b1; byteena_a = 4'hF;    data_a = 32'h01020304;
        address_b = 4'd11; wren_b = 1'b1; byteena_b = 4'b0011; data_b = 32'h0A0B0C0D;
        step();
        idle();
        repeat (LAT - 1) step();
        vec_cnt++;
        if (q_a !== 32'h01020304 || q_b !== 32'hA5A50C0D) begin
            err_cnt++;
            $display("FAIL indep_write: q_a=%h q_b=%h want 01020304/A5A50C0D", q_a, q_b);
        end
        address_a = 4'd11; address_b = 4'd10;
        repeat (LAT) step();
        vec_cnt++;
        if (q_a !== 32'hA5A50C0D || q_b !== 32'h01020304) begin
            err_cnt++;
            $display("FAIL indep_swap_read: q_a=%h q_b=%h want A5A50C0D/01020304", q_a, q_b);
        end
    endtask

    task automatic test_back_to_back();
        address_a = 4'd12; wren_a = 1'b1; byteena_a = 4'b0001; data_a = 32'h000000AA;
        address_b = 4'd13; wren_b = 1'b1; byteena_b = 4'b0000; data_b = 32'h12345678;
        step();
        wren_b = 1'b0;
        byteena_a = 4'b0010; data_a = 32'h0000BB00;
        step();
        idle();
        repeat (LAT - 1) step();
        vec_cnt++;
        if (q_a !== 32'hA5A5BBAA) begin
            err_cnt++;
            $display("FAIL b2b_merge: got %h want A5A5BBAA", q_a);
        end
        vec_cnt++;
        if (q_b !== IV) begin
            err_cnt++;
            $display("FAIL b2b_noop_be0: got %h want %h", q_b, IV);
        end
    endtask

    task automatic test_reset_mid_sweep();
        address_a = 4'd7; address_b = 4'd12;
        repeat (LAT) step();
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (init_busy !== 1'b1 || q_a !== '0 || q_b !== '0) begin
            err_cnt++;
            $display("FAIL async_reset: busy=%b q_a=%h q_b=%h want 1/0/0", init_busy, q_a, q_b);
        end
        step();
        reset = 1'b0;
        repeat (9) step();
        address_a = 4'd2; wren_a = 1'b1; byteena_a = 4'hF; data_a = 32'h12345678;
        #2;
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_sweep("mid_sweep");
        idle();
        address_a = 4'd2; address_b = 4'd7;
        repeat (LAT) step();
        vec_cnt++;
        if (q_a !== IV || q_b !== IV) begin
            err_cnt++;
            $display("FAIL after_reinit: q_a=%h q_b=%h want %h", q_a, q_b, IV);
        end
        address_a = 4'd5; address_b = 4'd12;
        repeat (LAT) step();
        vec_cnt++;
        if (q_a !== IV || q_b !== IV) begin
            err_cnt++;
            $display("FAIL reinit_overwrite: q_a=%h q_b=%h want %h", q_a, q_b, IV);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset   = 1'b1;
        address_a = '0; address_b = '0;
        idle();
        test_reset();
        test_init_contents();
        test_byte_write();
        test_dual_write_collision();
        test_cross_port_write_through();
        test_independent();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
